// File: rtl/pmult_result_queue.sv
// Capture stage behind the two-stage pmult: issues credit, aligns early flags
// with the late result word, canonicalises specials and queues results.
module pmult_result_queue #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             mult_out,
    input  logic                     mult_pinf,
    input  logic                     mult_pzero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
    output logic                     out_inf,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clear_stats,
    output logic [CNT_W-1:0]         inf_count,
    output logic [CNT_W-1:0]         zero_count,
    output logic                     err_overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic         inf;
        logic         zero;
        logic [N-1:0] data;
    } entry_t;

    logic [2:1]    vld_pipe;   // [1] = v1 (flags valid), [2] = v2 (out valid)
    logic [1:0]    flags;      // {pinf, pzero}
    logic [AW-1:0] wr_ptr, rd_ptr;
    entry_t        mem [DEPTH];
    entry_t        wr_ent, head;
    logic [AW+1:0] pending;
    logic          accept, full, wr_en, rd_en;

    // Credit counts in-flight pairs as occupied so the FIFO cannot overflow.
    assign pending  = (AW+2)'(count) + (AW+2)'(vld_pipe[1]) + (AW+2)'(vld_pipe[2]);
    assign in_ready = pending < (AW+2)'(DEPTH);
    assign accept   = in_valid & in_ready;

    assign wr_ent.inf  = flags[1];
    assign wr_ent.zero = flags[0] & ~flags[1];
    assign wr_ent.data = flags[1] ? {1'b1, {(N-1){1'b0}}} :
                         flags[0] ? '0 : mult_out;

    assign full      = count == (AW+1)'(DEPTH);
    assign wr_en     = vld_pipe[2] & ~full;
    assign out_valid = count != '0;
    assign rd_en     = out_valid & out_ready;

    assign head     = out_valid ? mem[rd_ptr] : '0;
    assign out_data = head.data;
    assign out_inf  = head.inf;
    assign out_zero = head.zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe     <= '0;
            flags        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            inf_count    <= '0;
            zero_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], accept};
            if (vld_pipe[1])
                flags <= {mult_pinf, mult_pzero};
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (vld_pipe[2] & full)
                err_overflow <= 1'b1;
            if (clear_stats)
                inf_count <= '0;
            else if (wr_en & wr_ent.inf & ~&inf_count)
                inf_count <= inf_count + 1'b1;
            if (clear_stats)
                zero_count <= '0;
            else if (wr_en & wr_ent.zero & ~&zero_count)
                zero_count <= zero_count + 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_ent;
    end

endmodule

// File: tb/tb_pmult_result_queue.sv
// Randomised scoreboard bench for pmult_result_queue with a transaction-level
// stand-in for pmult driving flags one cycle and the word two cycles after accept.
module tb_pmult_result_queue;
    localparam int N = 8, DEPTH = 4, CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic [N-1:0]     mult_out = '0;
    logic             mult_pinf = 1'b0, mult_pzero = 1'b0;
    logic             out_valid, out_ready = 1'b0;
    logic [N-1:0]     out_data;
    logic             out_inf, out_zero;
    logic [2:0]       count;
    logic             clear_stats = 1'b0;
    logic [CNT_W-1:0] inf_count, zero_count;
    logic             err_overflow;

    pmult_result_queue #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mult_out(mult_out), .mult_pinf(mult_pinf), .mult_pzero(mult_pzero),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inf(out_inf), .out_zero(out_zero), .count(count),
        .clear_stats(clear_stats), .inf_count(inf_count), .zero_count(zero_count),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       inf;
        logic       zero;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, errors = 0;
    int   m_inf = 0, m_zero = 0;
    // multiplier stand-in: stage 1 = flags on the wires, stage 2 = word on the wires
    logic       p1v = 0, p2v = 0, p1i = 0, p1z = 0, p2i = 0, p2z = 0;
    logic [7:0] p1o = 0, p2o = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    // One cycle: inputs were set 1ns after the previous edge; returns 1ns after the next.
    task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic ordy, input logic clr, output logic acc);
        logic       ni, nz;
        logic [7:0] no;
        exp_t       e;
        in_valid    = iv;
        out_ready   = ordy;
        clear_stats = clr;
        mult_pinf   = p1v ? p1i : 1'($urandom);
        mult_pzero  = p1v ? p1z : 1'($urandom);
        mult_out    = p2v ? p2o : 8'($urandom);
        acc = iv && in_ready;
        if (clr) begin
            m_inf  = 0;
            m_zero = 0;
        end else if (p2v) begin
            if (p2i)      m_inf++;
            else if (p2z) m_zero++;
        end
        ni = (a == 8'h80) || (b == 8'h80);
        nz = (a == 8'h00) || (b == 8'h00);
        no = (ni || nz) ? 8'($urandom) : 8'(a * b + 8'h11);
        if (acc) begin
            e.inf  = ni;
            e.zero = nz && !ni;
            e.d    = ni ? 8'h80 : (nz ? 8'h00 : no);
            sbq.push_back(e);
        end
        @(posedge clk);
        p2v = p1v; p2i = p1i; p2z = p1z; p2o = p1o;
        p1v = acc; p1i = ni;  p1z = nz;  p1o = no;
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && (sbq.size() != 0 || p1v || p2v); i++)
            step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        chk("drain_timeout", sbq.size(), 0);
    endtask

    // Scoreboard monitor: compares the head whenever the DUT presents one.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sbq.size() == 0)
                    chk("spurious_out_valid", 32'(out_valid), 0);
                else begin
                    chk("out_data", 32'(out_data), 32'(sbq[0].d));
                    chk("out_inf",  32'(out_inf),  32'(sbq[0].inf));
                    chk("out_zero", 32'(out_zero), 32'(sbq[0].zero));
                    if (out_ready) void'(sbq.pop_front());
                end
            end else
                chk("empty_head_zero", 32'({out_inf, out_zero, out_data}), 0);
        end
    end

    initial begin
        logic acc;
        int   n;
        logic [7:0] a, b;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_stats", 32'({inf_count, zero_count}), 0);
        chk("rst_err", 32'(err_overflow), 0);

        // single multiply: visible only in the cycle after edge k+2
        step(1'b1, 8'h50, 8'h50, 1'b1, 1'b0, acc);
        chk("single_accept", 32'(acc), 1);
        chk("lat_k", 32'(out_valid), 0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        chk("lat_k1", 32'(out_valid), 0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        chk("lat_k2", 32'(out_valid), 1);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        chk("lat_k3", 32'(out_valid), 0);

        // back-pressure: at most DEPTH pairs in total
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, acc);
            if (acc) begin
                n++;
                if (n == DEPTH) chk("bp_in_ready_low", 32'(in_ready), 0);
            end
        end
        chk("bp_accepts", n, DEPTH);
        chk("bp_count", 32'(count), DEPTH);
        chk("bp_err", 32'(err_overflow), 0);
        drain();

        // special operands
        for (int t = 0; t < 3; t++) begin
            case (t)
                0: begin a = 8'h80; b = 8'h40; end
                1: begin a = 8'h00; b = 8'h5A; end
                default: begin a = 8'h00; b = 8'h80; end
            endcase
            step(1'b1, a, b, 1'b1, 1'b0, acc);
            chk("special_accept", 32'(acc), 1);
            drain();
            chk("special_inf_count", 32'(inf_count), m_inf);
            chk("special_zero_count", 32'(zero_count), m_zero);
        end

        // sustained throughput: one accept per cycle with the consumer ready
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rand_op(), rand_op(), 1'b1, 1'b0, acc);
            if (acc) n++;
        end
        chk("throughput_accepts", n, 20);
        drain();

        // clear_stats coincident with a NaR write
        step(1'b1, 8'h80, 8'h40, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        chk("clear_wins", 32'(inf_count), m_inf);
        chk("clear_zero", 32'(zero_count), m_zero);
        drain();

        // randomised traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), rand_op(), rand_op(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0), acc);
        drain();
        chk("rand_inf_count", 32'(inf_count), m_inf);
        chk("rand_zero_count", 32'(zero_count), m_zero);
        chk("rand_err", 32'(err_overflow), 0);

        // reset with 2 stored and 2 in flight
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h50, 8'h3C, 1'b0, 1'b0, acc);
        chk("pre_rst_count", 32'(count), 2);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_out_valid", 32'(out_valid), 0);
        sbq.delete();
        p1v = 0; p2v = 0; m_inf = 0; m_zero = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
            chk("post_rst_quiet", 32'(out_valid), 0);
        end
        chk("post_rst_stats", 32'({inf_count, zero_count}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pmult_result_queue.md
# pmult_result_queue

Downstream capture stage for the fixed-regime posit multiplier `pmult` with N=8, es=2, regime=2. The multiplier has no handshake of its own. This block supplies the issue-side credit, `in_ready`, and tracks each accepted operand pair through the multiplier's two-stage pipeline. It aligns the early `pinf`/`pzero` flags with the late `out` word, substitutes canonical encodings for special results, and buffers results in a small FIFO with a valid/ready output port. It also keeps saturating counters of special-value results.

## Interface
Parameters:
- `N`, 8: posit width; must equal the multiplier's `N`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock, shared with `pmult`.
- `reset` in 1: asynchronous, active-high. It also drives `pmult`'s reset; assert it for at least one `clk` edge.
- `in_valid` in 1: upstream presents an operand pair on `pmult` `a`/`b` this cycle.
- `in_ready` out 1: the pair is accepted at this edge when `in_valid & in_ready`.
- `mult_out` in N: `pmult.out`.
- `mult_pinf` in 1: `pmult.pinf`.
- `mult_pzero` in 1: `pmult.pzero`.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer takes the head when `out_valid & out_ready`.
- `out_data` out N: head result word.
- `out_inf` out 1: head result is NaR.
- `out_zero` out 1: head result is zero.
- `count` out clog2(DEPTH)+1: FIFO occupancy.
- `clear_stats` in 1: synchronous clear of both counters.
- `inf_count` out CNT_W: saturating count of NaR results written.
- `zero_count` out CNT_W: saturating count of zero results written.
- `err_overflow` out 1: sticky; set if a write finds the FIFO full. Cleared only by `reset`.

## Operation
- **Tracking pipeline.**
  - `v1` is loaded with `in_valid & in_ready` at each edge.
  - `v2` is loaded with `v1`.
  - Flag register `f` is loaded with `{mult_pinf, mult_pzero}` at each edge where `v1=1`. This is when `pmult`'s flags are valid, one cycle before `out`.
- **Credit.**
  - `in_ready = (count + v1 + v2) < DEPTH`.
  - Pops in the current cycle are not credited.
  - The FIFO therefore can never overflow in legal operation.
- **Write.**
  - A write occurs at an edge where `v2=1`.
  - Entry is `{inf, zero, data}`, with `inf = f.pinf` and `zero = f.pzero & ~f.pinf`.
  - If `inf`, data = `{1'b1, {N-1{1'b0}}}` (8'h80).
  - Otherwise, if `zero`, data = 0.
  - Otherwise, data = `mult_out`.
- **FIFO.**
  - Circular buffer with wrap-around read/write pointers and an occupancy counter.
  - No bypass: a write into an empty FIFO becomes visible on the following cycle.
  - Simultaneous read and write leaves `count` unchanged.
  - A write with `count==DEPTH` is dropped and sets `err_overflow`.
- **Counters.**
  - `inf_count` increments on a write with `inf`; `zero_count` increments on a write with `zero`.
  - Both saturate at all-ones.
  - `clear_stats` wins over a coincident increment.

## Timing
- **Reset values** (applied immediately on `reset` assertion):
  - Registers: `v1=v2=0`, `f=0`, pointers 0, `count=0`, counters 0, `err_overflow=0`.
  - Outputs: `out_valid=0`, `in_ready=1` after reset; `out_data`, `out_inf`, `out_zero` = 0 while empty.
- **Latency:**
  - Pair accepted at edge k: `v1` is high after k, `v2` is high after k+1, the FIFO write occurs at edge k+2.
  - `out_valid` rises after edge k+2 if the FIFO was empty.
- **Throughput:** one result per cycle sustained while `out_ready=1`.
- **Back-pressure:** with `out_ready=0`, at most `DEPTH` pairs are accepted in total, counting both in-flight and stored pairs.
- **Output stability:** `out_data`, `out_inf` and `out_zero` are held stable while `out_valid & ~out_ready`.
- **Reset mid-operation:** in-flight and stored results are discarded. No stale result appears after `reset` deasserts.

## Test plan
- **Single multiply.** Accept a=8'h50, b=8'h50 at edge k, with `out_ready=1`.
  - `out_valid` is high in the cycle after edge k+2 only.
  - `out_data` equals `pmult`'s registered `out` for that pair.
  - Both flags are 0.
- **Back-pressure.** Hold `out_ready=0` and drive `in_valid=1` for 8 cycles.
  - Exactly 4 pairs are accepted.
  - `in_ready` falls after the 4th accept.
  - `count` reaches 4 and `err_overflow` stays 0.
  - Draining with `out_ready=1` returns results in order.
- **NaR operand.** a=8'h80, b=8'h40.
  - Result shows `out_data=8'h80`, `out_inf=1`, `out_zero=0`.
  - `inf_count` increments by 1.
- **Zero operand.** a=8'h00, b=8'h5A.
  - Result shows `out_data=8'h00`, `out_zero=1`.
  - `zero_count` increments by 1.
- **Zero times NaR.** a=8'h00, b=8'h80.
  - Result has `out_inf=1` and `out_zero=0`.
  - `inf_count` increments by 1 and `zero_count` is unchanged.
- **Reset and clear.**
  - Assert `reset` with 2 results stored and 2 in flight: `count=0` and `out_valid=0` immediately, and nothing appears afterwards.
  - Assert `clear_stats` together with a NaR write: `inf_count=0` after the edge.
